// File: rtl/lor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lor_pkg
//  Description : Shared helpers for the pipelined lower-part-OR adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package lor_pkg;

    // Widest segment the helper function can handle.
    localparam int LOR_SEG_MAX = 32;

    localparam int LOR_WIDTH_DEF  = 16;
    localparam int LOR_SEG_DEF    = 4;
    localparam int LOR_APPROX_DEF = 4;

    function automatic int lor_stages(input int width, input int seg);
        return width / seg;
    endfunction

    function automatic int lor_mask_width(input int approx_bits);
        return (approx_bits > 0) ? approx_bits : 1;
    endfunction

    // Static per-segment mask: bit j is set when global bit idx*seg+j lies
    // below the approximation boundary k.
    function automatic logic [LOR_SEG_MAX-1:0] lor_seg_mask(input int idx,
                                                            input int seg,
                                                            input int k);
        logic [LOR_SEG_MAX-1:0] m;
        m = '0;
        for (int j = 0; j < LOR_SEG_MAX; j++) begin
            m[j] = (j < seg) && ((idx * seg + j) < k);
        end
        return m;
    endfunction

    // Ripple segment adder. Masked bits produce a|b and pass a&b upward, so
    // the carry leaving the top masked bit is a[K-1]&b[K-1].
    function automatic logic [LOR_SEG_MAX:0] loa_seg(input logic [LOR_SEG_MAX-1:0] a_seg,
                                                     input logic [LOR_SEG_MAX-1:0] b_seg,
                                                     input logic                   cin,
                                                     input logic [LOR_SEG_MAX-1:0] approx_mask,
                                                     input int                     seg_w);
        logic [LOR_SEG_MAX-1:0] s;
        logic                   c;
        s = '0;
        c = cin;
        for (int i = 0; i < LOR_SEG_MAX; i++) begin
            if (i < seg_w) begin
                if (approx_mask[i]) begin
                    s[i] = a_seg[i] | b_seg[i];
                    c    = a_seg[i] & b_seg[i];
                end else begin
                    s[i] = a_seg[i] ^ b_seg[i] ^ c;
                    c    = (a_seg[i] & b_seg[i]) | (c & (a_seg[i] ^ b_seg[i]));
                end
            end
        end
        return {c, s};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lor_seg_stage.sv
`default_nettype none
// ============================================================================
//  Module      : lor_seg_stage
//  Description : One registered SEG-bit segment of the LOA pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module lor_seg_stage
    import lor_pkg::*;
#(
    parameter int WIDTH       = LOR_WIDTH_DEF,
    parameter int SEG         = LOR_SEG_DEF,
    parameter int APPROX_BITS = LOR_APPROX_DEF,
    parameter int IDX         = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_advance,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_carry,
    input  logic             i_approx,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_approx
);

    localparam logic [LOR_SEG_MAX-1:0] c_mask = lor_seg_mask(IDX, SEG, APPROX_BITS);

    logic [LOR_SEG_MAX-1:0] w_a_seg;
    logic [LOR_SEG_MAX-1:0] w_b_seg;
    logic [LOR_SEG_MAX-1:0] w_mask;
    logic [LOR_SEG_MAX-1:0] w_seg_sum;
    logic                   w_seg_carry;
    logic [WIDTH-1:0]       w_sum_next;

    logic                   r_valid;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [WIDTH-1:0]       r_sum;
    logic                   r_carry;
    logic                   r_approx;

    always_comb begin
        w_a_seg          = '0;
        w_b_seg          = '0;
        w_a_seg[SEG-1:0] = i_a[IDX*SEG +: SEG];
        w_b_seg[SEG-1:0] = i_b[IDX*SEG +: SEG];
        w_mask           = i_approx ? c_mask : '0;
        {w_seg_carry, w_seg_sum} = loa_seg(w_a_seg, w_b_seg, i_carry, w_mask, SEG);
        w_sum_next                = i_sum;
        w_sum_next[IDX*SEG +: SEG] = w_seg_sum[SEG-1:0];
    end

    generate
        if (SEG < LOR_SEG_MAX) begin : g_seg_hi
            logic w_unused_hi;
            assign w_unused_hi = ^w_seg_sum[LOR_SEG_MAX-1:SEG];
        end
    endgenerate

    // Data only loads with a valid transaction; bubbles just clear r_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_approx <= 1'b0;
        end else if (i_advance) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_a      <= i_a;
                r_b      <= i_b;
                r_sum    <= w_sum_next;
                r_carry  <= w_seg_carry;
                r_approx <= i_approx;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_a      = r_a;
    assign o_b      = r_b;
    assign o_sum    = r_sum;
    assign o_carry  = r_carry;
    assign o_approx = r_approx;

endmodule
`default_nettype wire

// File: rtl/lor_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : lor_adder_pipe
//  Description : Pipelined exact / lower-part-OR approximate adder with
//                valid/ready handshakes and a global stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module lor_adder_pipe
    import lor_pkg::*;
#(
    parameter int WIDTH       = LOR_WIDTH_DEF,
    parameter int SEG         = LOR_SEG_DEF,
    parameter int APPROX_BITS = LOR_APPROX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_approx
);

    localparam int STAGES = lor_stages(WIDTH, SEG);

    generate
        if ((WIDTH % SEG) != 0) begin : g_chk_seg_div
            $error("lor_adder_pipe: WIDTH must be a multiple of SEG");
        end
        if ((SEG < 1) || (SEG > LOR_SEG_MAX)) begin : g_chk_seg_range
            $error("lor_adder_pipe: SEG out of supported range");
        end
        if ((APPROX_BITS < 0) || (APPROX_BITS >= WIDTH)) begin : g_chk_approx
            $error("lor_adder_pipe: APPROX_BITS must be in 0..WIDTH-1");
        end
    endgenerate

    // Index 0 is the input side, index STAGES is the last stage register.
    logic             w_valid  [0:STAGES];
    logic [WIDTH-1:0] w_a      [0:STAGES];
    logic [WIDTH-1:0] w_b      [0:STAGES];
    logic [WIDTH-1:0] w_sum    [0:STAGES];
    logic             w_carry  [0:STAGES];
    logic             w_approx [0:STAGES];
    logic             w_advance;

    assign w_advance = !w_valid[STAGES] || out_ready;
    assign in_ready  = w_advance;

    assign w_valid[0]  = in_valid;
    assign w_a[0]      = a;
    assign w_b[0]      = b;
    assign w_sum[0]    = '0;
    assign w_approx[0] = approx_en;
    // With a nonzero OR region the incoming carry is discarded.
    assign w_carry[0]  = (approx_en && (APPROX_BITS > 0)) ? 1'b0 : cin;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            lor_seg_stage #(
                .WIDTH       (WIDTH),
                .SEG         (SEG),
                .APPROX_BITS (APPROX_BITS),
                .IDX         (gi)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .i_advance (w_advance),
                .i_valid   (w_valid[gi]),
                .i_a       (w_a[gi]),
                .i_b       (w_b[gi]),
                .i_sum     (w_sum[gi]),
                .i_carry   (w_carry[gi]),
                .i_approx  (w_approx[gi]),
                .o_valid   (w_valid[gi+1]),
                .o_a       (w_a[gi+1]),
                .o_b       (w_b[gi+1]),
                .o_sum     (w_sum[gi+1]),
                .o_carry   (w_carry[gi+1]),
                .o_approx  (w_approx[gi+1])
            );
        end
    endgenerate

    assign out_valid  = w_valid[STAGES];
    assign sum        = w_sum[STAGES];
    assign cout       = w_carry[STAGES];
    assign out_approx = w_approx[STAGES];

endmodule
`default_nettype wire

// File: tb/tb_lor_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lor_adder_pipe
//  Description : Self-checking bench for lor_adder_pipe (16/4/4 config).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lor_adder_pipe;

    localparam int W = 16;
    localparam int K = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          approx_en;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          out_approx;

    int n_checks = 0;
    int n_fail   = 0;
    bit sb_en    = 1'b0;
    logic [17:0] sb[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        ap;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    vec_t        vecs [12];
    logic [15:0] bp_a [8];
    logic [15:0] bp_b [8];
    logic [7:0]  bp_c;
    logic [7:0]  bp_p;

    lor_adder_pipe #(.WIDTH(16), .SEG(4), .APPROX_BITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .approx_en  (approx_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .cout       (cout),
        .out_approx (out_approx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: {cout, sum}
    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic ap);
        logic [16:0] h;
        logic [15:0] lowm;
        if (ap && (K > 0)) begin
            lowm = (16'h1 << K) - 16'h1;
            h    = 17'(x >> K) + 17'(y >> K) + 17'(x[K-1] & y[K-1]);
            return (h << K) | 17'((x | y) & lowm);
        end
        return 17'(x) + 17'(y) + 17'(c);
    endfunction

    // Scoreboard and stall-stability monitor, sampled mid low phase.
    logic [17:0] last_out;
    bit          prev_stall = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sb_en) begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_hold", 32'({cout, sum, out_approx}), 32'(last_out));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected", 32'd1, 32'd0);
                    end else begin
                        chk("sb_result", 32'({cout, sum, out_approx}), 32'(sb.pop_front()));
                    end
                end
                prev_stall = out_valid && !out_ready;
                last_out   = {cout, sum, out_approx};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; approx_en = v.ap;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(sum), 32'(v.sum));
        chk({tag, "_cout"}, 32'(cout), 32'(v.cout));
        chk({tag, "_approx"}, 32'(out_approx), 32'(v.ap));
    endtask

    task automatic stream(input int n, input bit rnd);
        int          sent = 0;
        int          cyc  = 0;
        int          viol = 0;
        bit          need = 1'b1;
        logic [15:0] ta = '0;
        logic [15:0] tb = '0;
        logic        tc = 1'b0;
        logic        tp = 1'b0;
        sb_en = 1'b1;
        while ((sent < n) && (cyc < n * 8 + 100)) begin
            @(negedge clk);
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            else     out_ready = !((cyc >= 5) && (cyc <= 7));
            if (need) begin
                if (rnd) begin
                    ta = 16'($urandom); tb = 16'($urandom);
                    tc = 1'($urandom);  tp = 1'($urandom);
                end else begin
                    ta = bp_a[sent]; tb = bp_b[sent];
                    tc = bp_c[sent]; tp = bp_p[sent];
                end
            end
            a = ta; b = tb; cin = tc; approx_en = tp; in_valid = 1'b1;
            #1;
            if (!rnd && !out_ready) chk("bp_in_ready", 32'(in_ready), 32'd0);
            if (out_ready && !in_ready) viol++;
            if (in_ready) begin
                sb.push_back({model(ta, tb, tc, tp), tp});
                sent++;
                need = 1'b1;
            end else begin
                need = 1'b0;
            end
            cyc++;
        end
        chk("stream_sent", 32'(sent), 32'(n));
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; (k < 20) && (sb.size() != 0); k++) @(negedge clk);
        #3;
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("ready_when_out_ready", 32'(viol), 32'd0);
        sb_en = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0};
        vecs[1]  = '{16'h0008, 16'h0008, 1'b0, 1'b1, 16'h0018, 1'b0};
        vecs[2]  = '{16'h000F, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b0};
        vecs[3]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[4]  = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0};
        vecs[5]  = '{16'h0008, 16'h0008, 1'b1, 1'b1, 16'h0018, 1'b0};
        vecs[6]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
        vecs[7]  = '{16'hFFF0, 16'h0010, 1'b0, 1'b1, 16'h0000, 1'b1};
        vecs[8]  = '{16'h00FF, 16'h00FF, 1'b0, 1'b1, 16'h01FF, 1'b0};
        vecs[9]  = '{16'h00FF, 16'h00FF, 1'b1, 1'b0, 16'h01FF, 1'b0};
        vecs[10] = '{16'hABCD, 16'h1111, 1'b1, 1'b1, 16'hBCDD, 1'b0};
        vecs[11] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};

        bp_a = '{16'h1234, 16'hFFFF, 16'h0008, 16'h00F0, 16'hABCD, 16'h7FFF, 16'h0F0F, 16'h8001};
        bp_b = '{16'h1111, 16'h0001, 16'h0008, 16'h0F0F, 16'h5432, 16'h0001, 16'hF0F1, 16'h8001};
        bp_c = 8'b1010_0101;
        bp_p = 8'b0110_1100;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        approx_en = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_out_approx", 32'(out_approx), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        repeat (2) @(negedge clk);
        stream(8, 1'b0);

        // Reset while three operations are in flight and the first is stalled.
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = bp_a[i]; b = bp_b[i]; cin = 1'b0; approx_en = 1'b0; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_pre_valid", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_async", 32'(out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("rst_mid_no_ghost", 32'(bad), 32'd0);
        run_vec(vecs[6], "post_rst");

        repeat (2) @(negedge clk);
        stream(10000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
